// File: rtl/dsp_result_round_sat.sv
// Post-MAC result conditioning: per-sample right shift with round-half-up,
// saturation to OUT_W bits, valid/ready output with backpressure and a
// sticky saturation event counter. Two register stages, one sample per cycle.
module dsp_result_round_sat #(
    parameter int IN_W   = 38,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  z_in,
    input  logic [5:0]       z_shift,
    input  logic             z_valid,
    output logic             z_ready,
    output logic [OUT_W-1:0] y,
    output logic             y_sat,
    output logic             y_valid,
    input  logic             y_ready,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_count
);

    // Shift with half-LSB rounding toward +infinity. One guard bit above
    // IN_W keeps the rounding add from overflowing in either mode.
    function automatic logic [IN_W:0] round_shift(input logic [IN_W-1:0] z,
                                                  input logic [5:0]      sh);
        logic        [IN_W:0] ext;
        logic        [IN_W:0] rc;
        logic signed [IN_W:0] sum_s;
        ext = (SIGNED != 0) ? {z[IN_W-1], z} : {1'b0, z};
        rc  = (sh == 6'd0) ? '0 : ({{IN_W{1'b0}}, 1'b1} << (sh - 6'd1));
        sum_s = $signed(ext + rc);
        if (SIGNED != 0)
            round_shift = $unsigned(sum_s >>> sh);
        else
            round_shift = $unsigned(sum_s) >> sh;
    endfunction

    // Clamp the rounded value into OUT_W bits; MSB of the result is the
    // clamp flag, the rest is the output word.
    function automatic logic [OUT_W:0] saturate(input logic [IN_W:0] r);
        logic [IN_W-OUT_W+1:0] top_s;
        logic [IN_W-OUT_W:0]   top_u;
        top_s = r[IN_W:OUT_W-1];
        top_u = r[IN_W:OUT_W];
        if (SIGNED != 0) begin
            // In range only when every bit above the output sign bit matches it.
            if ((&top_s) || !(|top_s))
                saturate = {1'b0, r[OUT_W-1:0]};
            else if (r[IN_W])
                saturate = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
            else
                saturate = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            if (|top_u)
                saturate = {1'b1, {OUT_W{1'b1}}};
            else
                saturate = {1'b0, r[OUT_W-1:0]};
        end
    endfunction

    logic             adv;
    logic [IN_W:0]    r_d;
    logic [IN_W:0]    r_q;
    logic             s1_valid_q;
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;
    logic             y_sat_d;
    logic             y_sat_q;
    logic             y_valid_q;
    logic [CNT_W-1:0] sat_count_d;
    logic [CNT_W-1:0] sat_count_q;

    // Pipeline advance, datapath next-state and counter next-state.
    always_comb begin
        adv          = !y_valid_q || y_ready;
        r_d          = round_shift(z_in, z_shift);
        {y_sat_d, y_d} = saturate(r_q);
        sat_count_d  = sat_count_q;
        if (sat_clr)
            sat_count_d = '0;
        else if (y_valid_q && y_ready && y_sat_q && !(&sat_count_q))
            sat_count_d = sat_count_q + CNT_W'(1);
    end

    // Stage 1 control: valid follows the input handshake while advancing.
    always_ff @(posedge clk) begin
        if (reset)
            s1_valid_q <= 1'b0;
        else if (adv)
            s1_valid_q <= z_valid;
    end

    // Stage 1 data: rounded/shifted accumulator value, no reset needed.
    always_ff @(posedge clk) begin
        if (adv)
            r_q <= r_d;
    end

    // Stage 2: saturated output word; only reloaded when stage 1 holds a
    // sample so the word is frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_valid_q <= 1'b0;
            y_q       <= '0;
            y_sat_q   <= 1'b0;
        end else if (adv) begin
            y_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                y_q     <= y_d;
                y_sat_q <= y_sat_d;
            end
        end
    end

    // Sticky saturation counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset)
            sat_count_q <= '0;
        else
            sat_count_q <= sat_count_d;
    end

    assign z_ready   = adv;
    assign y         = y_q;
    assign y_sat     = y_sat_q;
    assign y_valid   = y_valid_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_dsp_result_round_sat.sv
// Bench for dsp_result_round_sat: an unsigned instance (CNT_W=2) and a signed
// instance (CNT_W=16) share all inputs. A negedge scoreboard tracks every
// transfer against an arithmetic reference; directed tables and sequences
// cover rounding, clamping, backpressure, the counter and reset.
module tb_dsp_result_round_sat;

    typedef struct packed {
        logic [15:0] y;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [37:0] z;
        logic [5:0]  sh;
        logic [15:0] ya;
        logic        sa;
        logic [15:0] yb;
        logic        sb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] z_in = '0;
    logic [5:0]  z_shift = '0;
    logic        z_valid = 1'b0;
    logic        y_ready = 1'b0;
    logic        sat_clr = 1'b0;

    logic        za_ready, ya_sat, ya_valid;
    logic [15:0] ya;
    logic [1:0]  sat_count_a;
    logic        zb_ready, yb_sat, yb_valid;
    logic [15:0] yb;
    logic [15:0] sat_count_b;

    int n_pass  = 0;
    int n_total = 0;

    bit   mon_en = 1'b0;
    bit   log_en = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] logq[$];
    int   cnt_a = 0;
    int   cnt_b = 0;
    bit   stall_a = 1'b0;
    bit   stall_b = 1'b0;
    exp_t held_a, held_b;

    always #5 clk = ~clk;

    dsp_result_round_sat #(.IN_W(38), .OUT_W(16), .SIGNED(0), .CNT_W(2)) u_unsigned (
        .clk(clk), .reset(reset), .z_in(z_in), .z_shift(z_shift), .z_valid(z_valid),
        .z_ready(za_ready), .y(ya), .y_sat(ya_sat), .y_valid(ya_valid),
        .y_ready(y_ready), .sat_clr(sat_clr), .sat_count(sat_count_a)
    );

    dsp_result_round_sat #(.IN_W(38), .OUT_W(16), .SIGNED(1), .CNT_W(16)) u_signed (
        .clk(clk), .reset(reset), .z_in(z_in), .z_shift(z_shift), .z_valid(z_valid),
        .z_ready(zb_ready), .y(yb), .y_sat(yb_sat), .y_valid(yb_valid),
        .y_ready(y_ready), .sat_clr(sat_clr), .sat_count(sat_count_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: integer arithmetic on 64-bit values, floor division by 2^sh.
    function automatic exp_t model(input logic [37:0] z, input logic [5:0] sh, input bit sgn);
        longint v, half, r;
        exp_t   e;
        if (sgn) v = longint'($signed(z));
        else     v = longint'(z);
        half = (sh == 6'd0) ? 64'sd0 : (longint'(1) << (sh - 6'd1));
        r = (v + half) >>> sh;
        if (sgn) begin
            if (r > 32767)       e = '{16'h7FFF, 1'b1};
            else if (r < -32768) e = '{16'h8000, 1'b1};
            else                 e = '{r[15:0], 1'b0};
        end else begin
            if (r > 65535)       e = '{16'hFFFF, 1'b1};
            else                 e = '{r[15:0], 1'b0};
        end
        return e;
    endfunction

    // Scoreboard: sampled mid-cycle, decides what the next posedge transfers.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (reset) begin
                qa.delete();
                qb.delete();
                cnt_a   = 0;
                cnt_b   = 0;
                stall_a = 1'b0;
                stall_b = 1'b0;
            end else begin
                chk("sat_count_a", 64'(sat_count_a), 64'(cnt_a));
                chk("sat_count_b", 64'(sat_count_b), 64'(cnt_b));
                chk("z_ready_a", za_ready, !ya_valid || y_ready);
                chk("z_ready_b", zb_ready, !yb_valid || y_ready);
                if (stall_a) begin
                    chk("hold_valid_a", ya_valid, 1'b1);
                    chk("hold_y_a", {ya, ya_sat}, held_a);
                end
                if (stall_b) begin
                    chk("hold_valid_b", yb_valid, 1'b1);
                    chk("hold_y_b", {yb, yb_sat}, held_b);
                end
                stall_a = ya_valid && !y_ready;
                stall_b = yb_valid && !y_ready;
                held_a  = '{ya, ya_sat};
                held_b  = '{yb, yb_sat};
                if (z_valid && za_ready) qa.push_back(model(z_in, z_shift, 1'b0));
                if (z_valid && zb_ready) qb.push_back(model(z_in, z_shift, 1'b1));
                if (log_en && ya_valid && y_ready) logq.push_back(ya);
                if (ya_valid && y_ready) begin
                    if (qa.size() == 0) begin
                        chk("unexpected_out_a", 64'(ya_valid), 64'd0);
                        e = '{16'h0, 1'b0};
                    end else begin
                        e = qa.pop_front();
                        chk("out_a", {ya, ya_sat}, e);
                    end
                    if (sat_clr) cnt_a = 0;
                    else if (e.sat && cnt_a < 3) cnt_a++;
                end else if (sat_clr) cnt_a = 0;
                if (yb_valid && y_ready) begin
                    if (qb.size() == 0) begin
                        chk("unexpected_out_b", 64'(yb_valid), 64'd0);
                        e = '{16'h0, 1'b0};
                    end else begin
                        e = qb.pop_front();
                        chk("out_b", {yb, yb_sat}, e);
                    end
                    if (sat_clr) cnt_b = 0;
                    else if (e.sat && cnt_b < 65535) cnt_b++;
                end else if (sat_clr) cnt_b = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        bit   pat[8];
        int   idx, cyc, sent, mode;

        tbl[0] = '{38'h1234,        6'd0,  16'h1234, 1'b0, 16'h1234, 1'b0};
        tbl[1] = '{38'hFFFF60001,   6'd20, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1};
        tbl[2] = '{38'hFFFF60001,   6'd19, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1};
        tbl[3] = '{38'd24,          6'd4,  16'd2,    1'b0, 16'd2,    1'b0};
        tbl[4] = '{38'd23,          6'd4,  16'd1,    1'b0, 16'd1,    1'b0};
        tbl[5] = '{38'd8,           6'd4,  16'd1,    1'b0, 16'd1,    1'b0};
        tbl[6] = '{38'h3FFFFFFFE8,  6'd4,  16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
        tbl[7] = '{38'h8000,        6'd0,  16'h8000, 1'b0, 16'h7FFF, 1'b1};
        tbl[8] = '{38'h3FFFFF8000,  6'd0,  16'hFFFF, 1'b1, 16'h8000, 1'b0};
        tbl[9] = '{38'h7FFF,        6'd0,  16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset held with a valid input present.
        reset = 1'b1; z_valid = 1'b1; z_in = 38'd5; y_ready = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; z_valid = 1'b0;
        chk("rst_y_a", ya, 16'h0);
        chk("rst_y_sat_a", ya_sat, 1'b0);
        chk("rst_y_valid_a", ya_valid, 1'b0);
        chk("rst_y_valid_b", yb_valid, 1'b0);
        chk("rst_sat_count_a", 64'(sat_count_a), 64'd0);
        chk("rst_sat_count_b", 64'(sat_count_b), 64'd0);
        @(posedge clk); #1;
        chk("rst_z_ready_a", za_ready, 1'b1);
        chk("rst_y_valid_after_a", ya_valid, 1'b0);

        // Directed rounding / clamping table, one sample at a time.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            z_in = tbl[i].z; z_shift = tbl[i].sh; z_valid = 1'b1; y_ready = 1'b1;
            @(posedge clk); #1;
            z_valid = 1'b0;
            chk("lat_early_a", ya_valid, 1'b0);
            @(posedge clk); #1;
            chk("lat_valid_a", ya_valid, 1'b1);
            chk("lat_valid_b", yb_valid, 1'b1);
            chk("tbl_y_a", ya, tbl[i].ya);
            chk("tbl_sat_a", ya_sat, tbl[i].sa);
            chk("tbl_y_b", yb, tbl[i].yb);
            chk("tbl_sat_b", yb_sat, tbl[i].sb);
            if (i == 2) begin
                @(posedge clk); #1;
                chk("first_sat_count_a", 64'(sat_count_a), 64'd1);
                chk("first_sat_count_b", 64'(sat_count_b), 64'd2);
            end
        end

        // Counter: clear, then five saturating transfers on both instances.
        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("clr_count_a", 64'(sat_count_a), 64'd0);
        z_in = 38'h3FFFF00000; z_shift = 6'd0; z_valid = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        z_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        chk("sticky_count_a", 64'(sat_count_a), 64'd3);
        chk("count_b", 64'(sat_count_b), 64'd5);

        // Clear coinciding with a saturating output transfer.
        z_valid = 1'b1;
        @(posedge clk); #1;
        z_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_pending_valid_a", ya_valid, 1'b1);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("clr_vs_inc_a", 64'(sat_count_a), 64'd0);
        chk("clr_vs_inc_b", 64'(sat_count_b), 64'd0);

        // Backpressure: values 1..5 against a fixed ready pattern.
        logq.delete();
        log_en = 1'b1;
        idx = 0;
        cyc = 0;
        z_shift = 6'd0;
        while ((idx < 5 || cyc < 8) && cyc < 40) begin
            @(posedge clk); #1;
            y_ready = (cyc < 8) ? pat[cyc] : 1'b1;
            z_valid = (idx < 5);
            z_in    = 38'(idx + 1);
            @(negedge clk);
            if (z_valid && za_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        z_valid = 1'b0; y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        log_en = 1'b0;
        chk("bp_count", 64'(logq.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            chk("bp_order", (k < logq.size()) ? logq[k] : 16'hDEAD, 64'(k + 1));

        // Randomized regression with one reset in the middle of the stream.
        sent = 0;
        cyc  = 0;
        while (sent < 600 && cyc < 6000) begin
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
                chk("mid_rst_y_valid_a", ya_valid, 1'b0);
                chk("mid_rst_y_valid_b", yb_valid, 1'b0);
                chk("mid_rst_z_ready_a", za_ready, 1'b1);
            end
            z_valid = ($urandom_range(0, 9) < 7);
            y_ready = ($urandom_range(0, 9) < 7);
            sat_clr = ($urandom_range(0, 49) == 0);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                z_in    = {$urandom(), $urandom()};
                z_shift = 6'($urandom_range(0, 37));
            end else if (mode == 1) begin
                z_in    = 38'($urandom_range(0, 300000));
                z_shift = 6'($urandom_range(0, 6));
            end else begin
                z_in    = -38'($urandom_range(0, 300000));
                z_shift = 6'($urandom_range(0, 6));
            end
            if (cyc == 300) reset = 1'b1;
            @(negedge clk);
            if (z_valid && za_ready && !reset) sent++;
            cyc++;
        end
        chk("random_sent", 64'(sent), 64'd600);
        @(posedge clk); #1;
        z_valid = 1'b0; y_ready = 1'b1; sat_clr = 1'b0; reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_a", 64'(qa.size()), 64'd0);
        chk("drain_b", 64'(qb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
